// File: rtl/seq_unsigned_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// State encoding, divide-by-zero result pattern and counter-width helper.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Sliced down to WIDTH bits for quotient and remainder on a zero divisor.
  localparam logic [15:0] DBZ_ONES = 16'hFFFF;

  function automatic int cw_for(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_unsigned_divider_if.sv
// Operand/result bundle between a requester and the sequential divider.
interface seq_unsigned_divider_if #(
  parameter int WIDTH = 8
);

  logic             ena;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output ena, start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  ena, start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_unsigned_divider_step.sv
// One restoring shift-subtract iteration: shift {P,Q} left, trial-subtract D,
// keep the difference and set the new quotient bit when it does not underflow.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   p_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH:0]   p_o,
  output logic [WIDTH-1:0] q_o
);

  logic [2*WIDTH:0] pq_sh;
  logic [WIDTH:0]   p_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH:0]   trial;

  assign pq_sh = {p_i, q_i} << 1;
  assign p_sh  = pq_sh[2*WIDTH:WIDTH];
  assign q_sh  = pq_sh[WIDTH-1:0];
  assign trial = p_sh - {1'b0, d_i};

  // A set MSB means the subtraction borrowed: restore P, quotient bit is 0.
  assign p_o = trial[WIDTH] ? p_sh : trial;
  assign q_o = {q_sh[WIDTH-1:1], ~trial[WIDTH]};

endmodule

// File: rtl/seq_unsigned_divider.sv
// Multi-cycle unsigned divider, one quotient bit per enabled clock, with a
// start/busy/done handshake and a one-cycle divide-by-zero shortcut.
module seq_unsigned_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = cw_for(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_unsigned_divider_if.slave bus
);

  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   p_step;
  logic [WIDTH-1:0] q_step;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .p_i(p_q),
    .q_i(q_q),
    .d_i(d_q),
    .p_o(p_step),
    .q_o(q_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    if (bus.ena) begin
      case (state_q)
        IDLE, DONE: begin
          // DONE is a single-cycle pulse unless a new request arrives.
          state_d = IDLE;
          if (bus.start) begin
            if (bus.divisor == '0) begin
              state_d = DONE;
              quo_d   = DBZ_ONES[WIDTH-1:0];
              rem_d   = DBZ_ONES[WIDTH-1:0];
              dbz_d   = 1'b1;
            end else begin
              state_d = RUN;
              p_d     = '0;
              q_d     = bus.dividend;
              d_d     = bus.divisor;
              cnt_d   = '0;
            end
          end
        end
        RUN: begin
          p_d   = p_step;
          q_d   = q_step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_ITER) begin
            state_d = DONE;
            quo_d   = q_step;
            rem_d   = p_step[WIDTH-1:0];
            dbz_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_unsigned_divider.sv
// Scoreboard bench for seq_unsigned_divider at WIDTH=8 and WIDTH=4.
module tb_seq_unsigned_divider;

  typedef struct {
    int         a;
    int         b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_unsigned_divider_if #(.WIDTH(8)) bus8 ();
  seq_unsigned_divider_if #(.WIDTH(4)) bus4 ();

  seq_unsigned_divider #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  seq_unsigned_divider #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  exp_t sb8[$];
  exp_t sb4[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic exp_t model(input int w, input int a, input int b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.q   = 16'((1 << w) - 1);
      e.r   = 16'((1 << w) - 1);
      e.dbz = 1'b1;
    end else begin
      e.q   = 16'(a / b);
      e.r   = 16'(a % b);
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Called on a negedge; returns on the negedge just after the accepting edge.
  task automatic issue(input bit w4, input int a, input int b, input bit track);
    if (w4) begin
      bus4.dividend = 4'(a);
      bus4.divisor  = 4'(b);
      bus4.start    = 1'b1;
      if (track) sb4.push_back(model(4, a, b));
    end else begin
      bus8.dividend = 8'(a);
      bus8.divisor  = 8'(b);
      bus8.start    = 1'b1;
      if (track) sb8.push_back(model(8, a, b));
    end
    @(posedge clk);
    @(negedge clk);
    bus4.start = 1'b0;
    bus8.start = 1'b0;
  endtask

  // lat counts clock edges after the accepting edge until done is seen; -1 on timeout.
  task automatic wait_done(input bit w4, input int lat0, input int budget,
                           output int lat, output int busy_cnt);
    lat      = lat0;
    busy_cnt = 0;
    while (!(w4 ? bus4.done : bus8.done) && lat <= budget) begin
      if (w4 ? bus4.busy : bus8.busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (lat > budget) lat = -1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus8.busy, bus8.done, bus8.div_by_zero, bus8.quotient, bus8.remainder} !== '0) begin
      n_bad++;
      $display("FAIL reset8: got busy=%b done=%b dbz=%b q=%0d r=%0d, want all 0",
               bus8.busy, bus8.done, bus8.div_by_zero, bus8.quotient, bus8.remainder);
    end
    n_cmp++;
    if ({bus4.busy, bus4.done, bus4.div_by_zero, bus4.quotient, bus4.remainder} !== '0) begin
      n_bad++;
      $display("FAIL reset4: got busy=%b done=%b dbz=%b q=%0d r=%0d, want all 0",
               bus4.busy, bus4.done, bus4.div_by_zero, bus4.quotient, bus4.remainder);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Basic case, divide-by-zero and boundary operands on the 8-bit unit.
  task automatic test_basic();
    int   ta[6] = '{200, 5, 255, 0, 255, 7};
    int   tb[6] = '{7, 0, 255, 3, 1, 200};
    int   lat, bc, want_lat, want_bc;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, ta[i], tb[i], 1'b1);
      wait_done(1'b0, 0, 20, lat, bc);
      e        = sb8.pop_front();
      want_lat = (e.b == 0) ? 0 : 8;
      want_bc  = (e.b == 0) ? 0 : 8;
      $display("op8 %0d/%0d -> q=%0d r=%0d dbz=%b lat=%0d busy=%0d",
               e.a, e.b, bus8.quotient, bus8.remainder, bus8.div_by_zero, lat, bc);
      n_cmp++;
      if ({bus8.quotient, bus8.remainder, bus8.div_by_zero} !== {e.q[7:0], e.r[7:0], e.dbz}) begin
        n_bad++;
        $display("FAIL basic_result %0d/%0d: got q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=%b",
                 e.a, e.b, bus8.quotient, bus8.remainder, bus8.div_by_zero, e.q[7:0], e.r[7:0], e.dbz);
      end
      n_cmp++;
      if (lat !== want_lat || bc !== want_bc) begin
        n_bad++;
        $display("FAIL basic_timing %0d/%0d: got lat=%0d busy=%0d, want lat=%0d busy=%0d",
                 e.a, e.b, lat, bc, want_lat, want_bc);
      end
      @(negedge clk);
      n_cmp++;
      if (bus8.done !== 1'b0 || bus8.quotient !== e.q[7:0] || bus8.remainder !== e.r[7:0]) begin
        n_bad++;
        $display("FAIL basic_hold %0d/%0d: got done=%b q=%0d r=%0d, want done=0 q=%0d r=%0d",
                 e.a, e.b, bus8.done, bus8.quotient, bus8.remainder, e.q[7:0], e.r[7:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int   lat, bc;
    exp_t e;
    issue(1'b0, 200, 7, 1'b1);
    repeat (2) @(negedge clk);
    bus8.dividend = 8'd100;
    bus8.divisor  = 8'd9;
    bus8.start    = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    wait_done(1'b0, 3, 20, lat, bc);
    e = sb8.pop_front();
    $display("op8 %0d/%0d -> q=%0d r=%0d lat=%0d (start while busy)",
             e.a, e.b, bus8.quotient, bus8.remainder, lat);
    n_cmp++;
    if (bus8.quotient !== e.q[7:0] || bus8.remainder !== e.r[7:0] || lat !== 8) begin
      n_bad++;
      $display("FAIL ignore_busy_start: got q=%0d r=%0d lat=%0d, want q=%0d r=%0d lat=8",
               bus8.quotient, bus8.remainder, lat, e.q[7:0], e.r[7:0]);
    end
    issue(1'b0, 100, 9, 1'b1);
    n_cmp++;
    if (bus8.done !== 1'b0 || bus8.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_accept: got done=%b busy=%b, want done=0 busy=1", bus8.done, bus8.busy);
    end
    wait_done(1'b0, 0, 20, lat, bc);
    e = sb8.pop_front();
    $display("op8 %0d/%0d -> q=%0d r=%0d lat=%0d (back-to-back)",
             e.a, e.b, bus8.quotient, bus8.remainder, lat);
    n_cmp++;
    if (bus8.quotient !== e.q[7:0] || bus8.remainder !== e.r[7:0] || lat !== 8) begin
      n_bad++;
      $display("FAIL b2b_result: got q=%0d r=%0d lat=%0d, want q=%0d r=%0d lat=8",
               bus8.quotient, bus8.remainder, lat, e.q[7:0], e.r[7:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int seen;
    issue(1'b0, 200, 7, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("op8 200/7 aborted by reset");
    n_cmp++;
    if ({bus8.busy, bus8.done, bus8.div_by_zero, bus8.quotient, bus8.remainder} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_run: got busy=%b done=%b dbz=%b q=%0d r=%0d, want all 0",
               bus8.busy, bus8.done, bus8.div_by_zero, bus8.quotient, bus8.remainder);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.done === 1'b1 || bus8.busy === 1'b1) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL reset_no_done: got %0d active cycles after release, want 0", seen);
    end
  endtask

  task automatic test_w4_sweep();
    int   lat, bc;
    exp_t e;
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        issue(1'b1, a, b, 1'b1);
        wait_done(1'b1, 0, 12, lat, bc);
        e = sb4.pop_front();
        $display("op4 %0d/%0d -> q=%0d r=%0d lat=%0d", e.a, e.b, bus4.quotient, bus4.remainder, lat);
        n_cmp++;
        if (bus4.quotient !== e.q[3:0] || bus4.remainder !== e.r[3:0] || bus4.div_by_zero !== 1'b0) begin
          n_bad++;
          $display("FAIL w4_result %0d/%0d: got q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=0",
                   e.a, e.b, bus4.quotient, bus4.remainder, bus4.div_by_zero, e.q[3:0], e.r[3:0]);
        end
        n_cmp++;
        if (lat !== 4) begin
          n_bad++;
          $display("FAIL w4_latency %0d/%0d: got %0d, want 4", e.a, e.b, lat);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_ena_stall();
    int   lat, bc;
    exp_t e;
    issue(1'b1, 13, 3, 1'b1);
    repeat (2) @(negedge clk);
    bus4.ena = 1'b0;
    repeat (5) @(negedge clk);
    bus4.ena = 1'b1;
    wait_done(1'b1, 7, 20, lat, bc);
    e = sb4.pop_front();
    $display("op4 %0d/%0d -> q=%0d r=%0d lat=%0d (5-cycle ena stall)",
             e.a, e.b, bus4.quotient, bus4.remainder, lat);
    n_cmp++;
    if (bus4.quotient !== e.q[3:0] || bus4.remainder !== e.r[3:0] || lat !== 9) begin
      n_bad++;
      $display("FAIL ena_stall: got q=%0d r=%0d lat=%0d, want q=%0d r=%0d lat=9",
               bus4.quotient, bus4.remainder, lat, e.q[3:0], e.r[3:0]);
    end
    bus4.ena = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus4.done !== 1'b1 || bus4.quotient !== e.q[3:0]) begin
      n_bad++;
      $display("FAIL ena_hold_done: got done=%b q=%0d, want done=1 q=%0d",
               bus4.done, bus4.quotient, e.q[3:0]);
    end
    bus4.ena = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus4.done !== 1'b0) begin
      n_bad++;
      $display("FAIL ena_release_done: got done=%b, want 0", bus4.done);
    end
  endtask

  initial begin
    bus8.ena = 1'b1; bus8.start = 1'b0; bus8.dividend = '0; bus8.divisor = '0;
    bus4.ena = 1'b1; bus4.start = 1'b0; bus4.dividend = '0; bus4.divisor = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_mid_run();
    test_w4_sweep();
    test_ena_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
